// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator driving a synchronous instruction memory
// Ports: clk/rst_n (sync active-low); redirects next_select/jal_target (decode),
//   branch_result/branch_target and Jalr/jalr_target (execute); load stalls RUN;
//   imem_addr/imem_rdata talk to the memory; pre_address_fetch/instruction_fetch/
//   fetch_valid feed IF/ID; misalign_err is sticky when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_pc_unit #(
  parameter int ADDRESS = 32,
  parameter int INSTRUCTION = 32,
  parameter logic [ADDRESS-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic next_select,
  input  logic [ADDRESS-1:0] jal_target,
  input  logic branch_result,
  input  logic [ADDRESS-1:0] branch_target,
  input  logic Jalr,
  input  logic [ADDRESS-1:0] jalr_target,
  input  logic load,
  output logic [ADDRESS-1:0] imem_addr,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  output logic [ADDRESS-1:0] pre_address_fetch,
  output logic [INSTRUCTION-1:0] instruction_fetch,
  output logic fetch_valid,
  output logic misalign_err
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDRESS-1:0] pc_q, pc_d, target;
  logic [2:0] cnt_q, cnt_d;
  logic redirect;
  always_comb begin
    redirect = branch_result | Jalr | next_select;
    target = branch_result ? branch_target : Jalr ? jalr_target : jal_target;
    pc_d = redirect ? {target[ADDRESS-1:2], 2'b00}
         : ((state_q == RUN && load) || state_q == FLUSH) ? pc_q
         : pc_q + ADDRESS'(4);
    state_d = (redirect && FLUSH_CYCLES != 0) ? FLUSH
            : (!redirect && state_q == FLUSH && cnt_q != 3'd1) ? FLUSH
            : RUN;
    cnt_d = redirect ? 3'(FLUSH_CYCLES) : state_q == FLUSH ? cnt_q - 3'd1 : 3'd0;
  end
  // pc_q always tracks the address whose data the memory returns this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC - ADDRESS'(4);
      state_q <= BOOT;
      cnt_q <= 3'd0;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | (redirect & |target[1:0]);
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif
  // a redirect kills the younger instruction in the cycle it appears
  assign fetch_valid = state_q == RUN && !redirect;
  assign imem_addr = pc_d;
  assign pre_address_fetch = fetch_valid ? pc_q : '0;
  assign instruction_fetch = fetch_valid ? imem_rdata : '0;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit with a word=address memory
module tb_fetch_pc_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic next_select = 1'b0, branch_result = 1'b0, Jalr = 1'b0, load = 1'b0;
  logic [31:0] jal_target = '0, branch_target = '0, jalr_target = '0;
  logic [31:0] imem_addr, imem_rdata, pre_address_fetch, instruction_fetch;
  logic fetch_valid, misalign_err;
  int vectors = 0, miss = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  fetch_pc_unit #(.RESET_PC(32'h100), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .next_select(next_select), .jal_target(jal_target),
    .branch_result(branch_result), .branch_target(branch_target), .Jalr(Jalr),
    .jalr_target(jalr_target), .load(load), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pre_address_fetch(pre_address_fetch),
    .instruction_fetch(instruction_fetch), .fetch_valid(fetch_valid),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic ev, input logic [31:0] ep);
    #1;
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, ev});
    chk("pre_address_fetch", pre_address_fetch, ev ? ep : 32'd0);
    chk("instruction_fetch", instruction_fetch, ev ? ep : 32'd0);
    @(negedge clk);
  endtask
  task automatic clr();
    next_select = 0; branch_result = 0; Jalr = 0; load = 0;
  endtask
  initial begin
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("boot_imem_addr", imem_addr, 32'h100);
    chk("reset_err", {31'd0, misalign_err}, 32'd0);
    step(0, 0);
    step(1, 32'h100);
    step(1, 32'h104);
    load = 1; step(1, 32'h108);
    step(1, 32'h108);
    load = 0; step(1, 32'h108);
    branch_result = 1; branch_target = 32'h200; step(0, 0);
    clr(); step(0, 0); step(0, 0);
    step(1, 32'h200);
    step(1, 32'h204);
    branch_result = 1; branch_target = 32'h300; next_select = 1; jal_target = 32'h400;
    #1 chk("prio_imem_addr", imem_addr, 32'h300);
    step(0, 0);
    clr(); step(0, 0); step(0, 0);
    step(1, 32'h300);
    next_select = 1; jal_target = 32'h700; step(0, 0);
    clr(); Jalr = 1; jalr_target = 32'h500; step(0, 0);
    clr(); step(0, 0); step(0, 0);
    step(1, 32'h500);
    next_select = 1; jal_target = 32'h602;
    #1 chk("misalign_imem_addr", imem_addr, 32'h600);
    step(0, 0);
    clr();
    #1 chk("misalign_err_set", {31'd0, misalign_err}, {31'd0, EXP_ERR});
    step(0, 0); step(0, 0);
    step(1, 32'h600);
    #1 chk("misalign_err_sticky", {31'd0, misalign_err}, {31'd0, EXP_ERR});
    load = 1; branch_result = 1; branch_target = 32'h800; step(0, 0);
    clr(); step(0, 0); step(0, 0);
    step(1, 32'h800);
    branch_result = 1; branch_target = 32'h900; step(0, 0);
    clr(); rst_n = 0; @(negedge clk);
    rst_n = 1;
    #1 chk("reset_clears_err", {31'd0, misalign_err}, 32'd0);
    step(0, 0);
    step(1, 32'h100);
    branch_result = 1; branch_target = 32'hFFFF_FFFC; step(0, 0);
    clr(); step(0, 0); step(0, 0);
    step(1, 32'hFFFF_FFFC);
    step(1, 32'h0);
    step(1, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
